// File: rtl/bn_relu_maxpool.sv
// Streaming ReLU + 1-D max-pool stage behind the BN processing element.
// Define BN_RELU_MAXPOOL_RELU_EN to clamp negative samples to zero.
module bn_relu_maxpool #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 4,
  parameter int POOL     = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          out_ch
);

  localparam int WIN_W = (POOL > 1) ? $clog2(POOL) : 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(POOL - 1);

  logic [CH_W-1:0]          ch_cnt;
  logic [WIN_W-1:0]         win_cnt;
  logic signed [DATA_W-1:0] acc [CHANNELS];
  logic signed [DATA_W-1:0] v;
  logic signed [DATA_W-1:0] cur;
  logic signed [DATA_W-1:0] mx;
  logic signed [DATA_W-1:0] res;
  logic                     first;
  logic                     last;

`ifdef BN_RELU_MAXPOOL_RELU_EN
  assign v = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign v = in_data;
`endif

  assign cur   = acc[ch_cnt];
  assign mx    = (cur > v) ? cur : v;
  assign first = (win_cnt == '0);
  assign last  = (win_cnt == WIN_LAST);
  // First sample of a window loads directly, so POOL == 1 echoes v
  assign res   = first ? v : mx;

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt    <= '0;
      win_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      for (int i = 0; i < CHANNELS; i++)
        acc[i] <= '0;
    end else if (flush) begin
      ch_cnt    <= '0;
      win_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid && last;
      if (in_valid) begin
        acc[ch_cnt] <= res;
        if (last) begin
          out_data <= res;
          out_ch   <= ch_cnt;
        end
        if (ch_cnt == CH_LAST) begin
          ch_cnt  <= '0;
          win_cnt <= last ? '0 : win_cnt + 1'b1;
        end else begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bn_relu_maxpool.sv
// Randomized scoreboard bench for bn_relu_maxpool.
// Two instances: 4ch/pool3 and 3ch/pool1 share one input stream.
module tb_bn_relu_maxpool;

  localparam int DW = 16;
  localparam int CA = 4;
  localparam int PA = 3;
  localparam int CB = 3;
  localparam int PB = 1;

  typedef struct {
    int ch;
    int val;
    int cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 flush;
  logic signed [DW-1:0] in_data;
  logic                 oa_v;
  logic                 ob_v;
  logic signed [DW-1:0] oa_d;
  logic signed [DW-1:0] ob_d;
  logic [1:0]           oa_ch;
  logic [1:0]           ob_ch;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   en = 1'b0;
  int   ka = 0;
  int   kb = 0;
  int   wa[$];
  int   wb[$];
  exp_t qa[$];
  exp_t qb[$];
  exp_t lasta = '{0, 0, 0};
  exp_t lastb = '{0, 0, 0};

  int seq1[12] = '{-32768, 32767, 0, -1,
                   -1, -32768, 32767, 0,
                   0, -1, -32768, 32767};

  bn_relu_maxpool #(.DATA_W(DW), .CHANNELS(CA), .POOL(PA)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .out_valid(oa_v), .out_data(oa_d), .out_ch(oa_ch)
  );

  bn_relu_maxpool #(.DATA_W(DW), .CHANNELS(CB), .POOL(PB)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .out_valid(ob_v), .out_data(ob_d), .out_ch(ob_ch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int relu(input int d);
`ifdef BN_RELU_MAXPOOL_RELU_EN
    return (d < 0) ? 0 : d;
`else
    return d;
`endif
  endfunction

  // Reference: sample k of a window is channel k%C; close when k/C == P-1
  task automatic model(input int id, input int v);
    int   C;
    int   P;
    int   k;
    int   c;
    int   m;
    exp_t e;
    C = (id == 0) ? CA : CB;
    P = (id == 0) ? PA : PB;
    k = (id == 0) ? ka : kb;
    c = k % C;
    if (id == 0) wa.push_back(v);
    else wb.push_back(v);
    if (k / C == P - 1) begin
      m = v;
      for (int j = 0; j < k; j++) begin
        if (j % C == c) begin
          int w;
          w = (id == 0) ? wa[j] : wb[j];
          if (w > m) m = w;
        end
      end
      e.ch  = c;
      e.val = m;
      e.cyc = cyc + 1;
      if (id == 0) qa.push_back(e);
      else qb.push_back(e);
    end
    k++;
    if (k == C * P) begin
      k = 0;
      if (id == 0) wa.delete();
      else wb.delete();
    end
    if (id == 0) ka = k;
    else kb = k;
  endtask

  task automatic step(input bit r, input bit f, input bit vld, input int d);
    @(negedge clk);
    rst      = r;
    flush    = f;
    in_valid = vld;
    in_data  = DW'(d);
    if (r) begin
      ka = 0;
      kb = 0;
      wa.delete();
      wb.delete();
      lasta = '{0, 0, 0};
      lastb = '{0, 0, 0};
    end else if (f) begin
      ka = 0;
      kb = 0;
      wa.delete();
      wb.delete();
    end else if (vld) begin
      model(0, relu(d));
      model(1, relu(d));
    end
  endtask

  task automatic check(input int id, input logic v,
                       input logic [DW-1:0] d, input logic [1:0] ch);
    exp_t e;
    exp_t l;
    int   sz;
    if (id == 0) begin
      sz = qa.size();
      l  = lasta;
    end else begin
      sz = qb.size();
      l  = lastb;
    end
    n_chk++;
    if (v) begin
      if (sz == 0) begin
        n_fail++;
        $display("FAIL out%0d_spurious: got ch=%0d data=%0d at cyc %0d, required no output",
                 id, ch, $signed(d), cyc);
      end else begin
        if (id == 0) e = qa.pop_front();
        else e = qb.pop_front();
        if (d !== DW'(e.val) || ch !== 2'(e.ch) || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL out%0d_result: got ch=%0d data=%0d cyc=%0d, required ch=%0d data=%0d cyc=%0d",
                   id, ch, $signed(d), cyc, e.ch, e.val, e.cyc);
        end
        if (id == 0) lasta = e;
        else lastb = e;
      end
    end else begin
      if (d !== DW'(l.val) || ch !== 2'(l.ch)) begin
        n_fail++;
        $display("FAIL out%0d_hold: got ch=%0d data=%0d at cyc %0d, required ch=%0d data=%0d",
                 id, ch, $signed(d), cyc, l.ch, l.val);
      end
      if (sz != 0) begin
        if (id == 0) e = qa[0];
        else e = qb[0];
        if (e.cyc <= cyc) begin
          n_fail++;
          $display("FAIL out%0d_missing: got no output at cyc %0d, required ch=%0d data=%0d",
                   id, cyc, e.ch, e.val);
          if (id == 0) void'(qa.pop_front());
          else void'(qb.pop_front());
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (en) begin
      check(0, oa_v, oa_d, oa_ch);
      check(1, ob_v, ob_d, ob_ch);
    end
  end

  initial begin
    int r;
    int pick;
    int d;
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    step(1, 0, 0, 0);
    en = 1'b1;
    step(0, 0, 0, 0);
    foreach (seq1[i]) step(0, 0, 1, seq1[i]);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, seq1[(i * 5) % 12]);
      repeat (3) step(0, 0, 0, 0);
    end
    for (int i = 0; i < 7; i++) step(0, 0, 1, 10 + i);
    step(0, 1, 0, 0);
    step(0, 1, 1, 99);
    for (int i = 1; i <= 12; i++) step(0, 0, 1, i);
    for (int i = 0; i < 5; i++) step(0, 0, 1, -3 * i);
    step(1, 0, 1, 500);
    step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 100 - i * 7);
    repeat (3000) begin
      r    = int'($urandom_range(0, 999));
      pick = int'($urandom_range(0, 7));
      if (pick == 0) d = -32768;
      else if (pick == 1) d = 32767;
      else d = int'($urandom_range(0, 65535)) - 32768;
      step(r == 0, r >= 1 && r <= 10, r < 700, d);
    end
    repeat (5) step(0, 0, 0, 0);
    n_chk++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d outputs outstanding, required 0/0",
               qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
